// File: rtl/instruction_encoder_pkg.sv
// Shared RV32I definitions: instruction formats, field types, opcodes and
// immediate ranges. The instruction decoder imports the same package.
package definitions;

    typedef logic [31:0] t_data;
    typedef logic [4:0]  t_register_index;

    // Encodings 5..7 are not formats; the encoder drops requests carrying them.
    typedef enum logic [2:0] {
        FORMAT_OP_IMM = 3'd0,
        FORMAT_OP     = 3'd1,
        FORMAT_BRANCH = 3'd2,
        FORMAT_STORE  = 3'd3,
        FORMAT_JAL    = 3'd4
    } t_instr_format;

    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

    // Legal signed immediate ranges (byte offsets for B and J).
    localparam int IMM_I_MIN = -2048;
    localparam int IMM_I_MAX = 2047;
    localparam int IMM_B_MIN = -4096;
    localparam int IMM_B_MAX = 4094;
    localparam int IMM_J_MIN = -1048576;
    localparam int IMM_J_MAX = 1048574;

    // SLLI and SRLI/SRAI carry a 5-bit shift amount instead of a 12-bit immediate.
    function automatic logic is_shift_funct3(input logic [2:0] funct3);
        return (funct3 == 3'b001) || (funct3 == 3'b101);
    endfunction

endpackage

// File: rtl/instruction_encoder_if.sv
// Request/response bundle of the instruction encoder. The slave modport is
// the encoder itself; the master modport is the program generator side that
// issues requests and drains encoded words.
interface instruction_encoder_if #(
    parameter int ADDR_WIDTH = 8
);
    import definitions::*;

    // Request side
    logic            i_valid;
    logic            o_ready;
    t_instr_format   i_format;
    logic [2:0]      i_funct3;
    logic            i_arith;
    t_register_index i_destination_register;
    t_register_index i_source_register1;
    t_register_index i_source_register2;
    t_data           i_immediate;

    // Output side
    logic                  o_valid;
    logic                  i_ready;
    t_data                 o_instruction;
    logic [ADDR_WIDTH-1:0] o_address;
    logic                  o_error;

    modport slave (
        input  i_valid, i_format, i_funct3, i_arith,
               i_destination_register, i_source_register1, i_source_register2,
               i_immediate, i_ready,
        output o_ready, o_valid, o_instruction, o_address, o_error
    );

    modport master (
        output i_valid, i_format, i_funct3, i_arith,
               i_destination_register, i_source_register1, i_source_register2,
               i_immediate, i_ready,
        input  o_ready, o_valid, o_instruction, o_address, o_error
    );

endinterface

// File: rtl/encoder_word_fifo.sv
// Two-entry FIFO of {address, word}. Entries live in a head register and a
// second register so the output is always a flop, never a read mux.
// Flush empties the FIFO without clearing the stored data.
module encoder_word_fifo #(
    parameter int WIDTH = 40
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    logic [1:0]       count_q;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] second_q;
    logic             do_push;
    logic             do_pop;

    assign full      = (count_q == 2'd2);
    assign empty     = (count_q == 2'd0);
    assign head_data = head_q;
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;

    // Occupancy and entry storage; a pop and a push at occupancy 1 replace the head.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values,
            // whatever the statement order.
            count_q  <= 2'd0;
            // NOTE: only two entries, and the head must read as zero after reset,
            // so the storage is reset; a deep RAM-backed FIFO would not be.
            head_q   <= '0;
            second_q <= '0;
        end else if (i_flush) begin
            count_q <= 2'd0;
        end else begin
            unique case ({do_push, do_pop})
                2'b10: begin
                    if (count_q == 2'd0) head_q <= push_data;
                    else                 second_q <= push_data;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) head_q <= second_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    // Push is only possible below full, so occupancy is 1 here.
                    head_q <= push_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/instruction_encoder.sv
// Pipelined RV32I instruction encoder: packs field-level requests into 32-bit
// words, tags each with an auto-incrementing instruction-memory word address
// and drains them through a two-entry buffer.
// Optional feature macro: IMM_RANGE_CHECK_EN -- when defined, out-of-range
// immediates are dropped and flagged instead of being silently truncated.
module instruction_encoder
    import definitions::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input logic                  i_clk,
    input logic                  i_reset,
    input logic                  i_flush,
    instruction_encoder_if.slave bus
);

    localparam int ENTRY_WIDTH = ADDR_WIDTH + 32;

    logic [ADDR_WIDTH-1:0]  address_q;
    logic                   error_q;
    t_data                  packed_word;
    logic                   format_ok;
    logic                   imm_ok;
    logic                   accept;
    logic                   drop;
    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   empty;
    logic [ENTRY_WIDTH-1:0] head_entry;

    // Pack the request fields into a machine word; unused fields stay zero.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        packed_word = '0;
        format_ok   = 1'b1;
        case (bus.i_format)
            FORMAT_OP_IMM: begin
                if (is_shift_funct3(bus.i_funct3)) begin
                    packed_word = {1'b0, bus.i_arith, 5'b0, bus.i_immediate[4:0],
                                   bus.i_source_register1, bus.i_funct3,
                                   bus.i_destination_register, OPCODE_OP_IMM};
                end else begin
                    packed_word = {bus.i_immediate[11:0],
                                   bus.i_source_register1, bus.i_funct3,
                                   bus.i_destination_register, OPCODE_OP_IMM};
                end
            end
            FORMAT_OP: begin
                packed_word = {1'b0, bus.i_arith, 5'b0, bus.i_source_register2,
                               bus.i_source_register1, bus.i_funct3,
                               bus.i_destination_register, OPCODE_OP};
            end
            FORMAT_BRANCH: begin
                packed_word = {bus.i_immediate[12], bus.i_immediate[10:5],
                               bus.i_source_register2, bus.i_source_register1,
                               bus.i_funct3, bus.i_immediate[4:1],
                               bus.i_immediate[11], OPCODE_BRANCH};
            end
            FORMAT_STORE: begin
                packed_word = {bus.i_immediate[11:5], bus.i_source_register2,
                               bus.i_source_register1, bus.i_funct3,
                               bus.i_immediate[4:0], OPCODE_STORE};
            end
            FORMAT_JAL: begin
                packed_word = {bus.i_immediate[20], bus.i_immediate[10:1],
                               bus.i_immediate[11], bus.i_immediate[19:12],
                               bus.i_destination_register, OPCODE_JAL};
            end
            default: format_ok = 1'b0;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // Reject immediates that do not fit the field of the requested format.
    always_comb begin
        imm_ok = 1'b1;
        case (bus.i_format)
            FORMAT_OP_IMM: begin
                if (is_shift_funct3(bus.i_funct3)) begin
                    imm_ok = (bus.i_immediate[31:5] == '0);
                end else begin
                    imm_ok = ($signed(bus.i_immediate) >= IMM_I_MIN) &&
                             ($signed(bus.i_immediate) <= IMM_I_MAX);
                end
            end
            FORMAT_STORE: begin
                imm_ok = ($signed(bus.i_immediate) >= IMM_I_MIN) &&
                         ($signed(bus.i_immediate) <= IMM_I_MAX);
            end
            FORMAT_BRANCH: begin
                imm_ok = ($signed(bus.i_immediate) >= IMM_B_MIN) &&
                         ($signed(bus.i_immediate) <= IMM_B_MAX) &&
                         !bus.i_immediate[0];
            end
            FORMAT_JAL: begin
                imm_ok = ($signed(bus.i_immediate) >= IMM_J_MIN) &&
                         ($signed(bus.i_immediate) <= IMM_J_MAX) &&
                         !bus.i_immediate[0];
            end
            default: imm_ok = 1'b1;
        endcase
    end
`else
    // Without range checking immediates are truncated; the upper bits never reach a field.
    logic unused_imm_bits;
    assign imm_ok          = 1'b1;
    assign unused_imm_bits = ^bus.i_immediate[31:21];
`endif

    // Handshake: o_ready depends only on buffer occupancy, never on i_ready.
    assign accept = bus.i_valid && !full && !i_flush && !i_reset;
    assign drop   = accept && !(format_ok && imm_ok);
    assign push   = accept && format_ok && imm_ok;
    assign pop    = !empty && bus.i_ready;

    // Address counter and sticky drop flag; reset and flush both restart from zero.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            address_q <= '0;
            error_q   <= 1'b0;
        end else begin
            if (push) address_q <= address_q + 1'b1;
            if (drop) error_q   <= 1'b1;
        end
    end

    encoder_word_fifo #(
        .WIDTH (ENTRY_WIDTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_flush   (i_flush),
        .push      (push),
        .push_data ({address_q, packed_word}),
        .pop       (pop),
        .head_data (head_entry),
        .full      (full),
        .empty     (empty)
    );

    assign bus.o_ready       = !full;
    assign bus.o_valid       = !empty;
    assign bus.o_instruction = head_entry[31:0];
    assign bus.o_address     = head_entry[ENTRY_WIDTH-1:32];
    assign bus.o_error       = error_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench for instruction_encoder. Two encoders (ADDR_WIDTH 8 and
// 2) receive identical stimulus; a queue-based reference model predicts the
// head word, address, ready and error of both every cycle.
module tb_instruction_encoder;
    import definitions::*;

    logic i_clk = 1'b0;
    logic i_reset;
    logic i_flush;

    always #5 i_clk = ~i_clk;

    instruction_encoder_if #(.ADDR_WIDTH(8)) bus ();
    instruction_encoder_if #(.ADDR_WIDTH(2)) bus_w ();

    assign bus_w.i_valid                = bus.i_valid;
    assign bus_w.i_format               = bus.i_format;
    assign bus_w.i_funct3               = bus.i_funct3;
    assign bus_w.i_arith                = bus.i_arith;
    assign bus_w.i_destination_register = bus.i_destination_register;
    assign bus_w.i_source_register1     = bus.i_source_register1;
    assign bus_w.i_source_register2     = bus.i_source_register2;
    assign bus_w.i_immediate            = bus.i_immediate;
    assign bus_w.i_ready                = bus.i_ready;

    instruction_encoder #(.ADDR_WIDTH(8)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_flush (i_flush),
        .bus     (bus)
    );

    instruction_encoder #(.ADDR_WIDTH(2)) dut_w (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_flush (i_flush),
        .bus     (bus_w)
    );

    typedef struct {
        int unsigned addr;
        logic [31:0] word;
    } t_expected;

    t_expected   exp_q[$];
    int unsigned model_count;
    bit          model_error;
    int          vectors;
    int          miscompares;

    // ---------------- reference model ----------------
    // Copy imm[hi:lo] into the word starting at bit dst.
    function automatic logic [31:0] scatter(input logic [31:0] imm, input int lo,
                                            input int hi, input int dst);
        logic [31:0] w = '0;
        for (int b = lo; b <= hi; b++)
            if (imm[b]) w = w + (32'd1 << (dst + b - lo));
        return w;
    endfunction

    function automatic logic [31:0] model_encode(input logic [2:0] fmt, input logic [2:0] f3,
                                                 input logic arith, input logic [4:0] rd,
                                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                                 input logic [31:0] imm);
        logic [31:0] common = (32'(f3) << 12) + (32'(rs1) << 15);
        logic [31:0] a30    = arith ? 32'h4000_0000 : 32'h0;
        case (fmt)
            3'd0: begin
                if (f3 == 3'd1 || f3 == 3'd5)
                    return 32'h13 + (32'(rd) << 7) + common + scatter(imm, 0, 4, 20) + a30;
                return 32'h13 + (32'(rd) << 7) + common + scatter(imm, 0, 11, 20);
            end
            3'd1: return 32'h33 + (32'(rd) << 7) + common + (32'(rs2) << 20) + a30;
            3'd2: return 32'h63 + common + (32'(rs2) << 20) + scatter(imm, 1, 4, 8)
                         + scatter(imm, 5, 10, 25) + scatter(imm, 11, 11, 7)
                         + scatter(imm, 12, 12, 31);
            3'd3: return 32'h23 + common + (32'(rs2) << 20) + scatter(imm, 0, 4, 7)
                         + scatter(imm, 5, 11, 25);
            3'd4: return 32'h6F + (32'(rd) << 7) + scatter(imm, 1, 10, 21)
                         + scatter(imm, 11, 11, 20) + scatter(imm, 12, 19, 12)
                         + scatter(imm, 20, 20, 31);
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit model_legal(input logic [2:0] fmt, input logic [2:0] f3,
                                       input logic [31:0] imm);
        int v = $signed(imm);
        if (fmt > 3'd4) return 1'b0;
`ifdef IMM_RANGE_CHECK_EN
        case (fmt)
            3'd0:    return (f3 == 3'd1 || f3 == 3'd5) ? (v >= 0 && v <= 31)
                                                       : (v >= -2048 && v <= 2047);
            3'd2:    return v >= -4096 && v <= 4094 && imm[0] == 1'b0;
            3'd3:    return v >= -2048 && v <= 2047;
            3'd4:    return v >= -1048576 && v <= 1048574 && imm[0] == 1'b0;
            default: return 1'b1;
        endcase
`else
        return 1'b1 || (f3 == 3'd0 && v == 0);
`endif
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input logic [2:0] fmt, input logic [2:0] f3, input logic arith,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] imm);
        bus.i_valid                = 1'b1;
        bus.i_format               = t_instr_format'(fmt);
        bus.i_funct3               = f3;
        bus.i_arith                = arith;
        bus.i_destination_register = rd;
        bus.i_source_register1     = rs1;
        bus.i_source_register2     = rs2;
        bus.i_immediate            = imm;
    endtask

    task automatic idle();
        bus.i_valid = 1'b0;
    endtask

    // One clock: compare both encoders against the model just before the edge,
    // advance the model with the inputs in force, then move to just after the edge.
    task automatic step();
        logic        ov[2], ordy[2], oerr[2];
        logic [31:0] ow[2];
        int unsigned oa[2];
        int unsigned modulo[2];
        bit          ev, er, pop_m, acc;
        logic [31:0] word;
        @(negedge i_clk);
        ov[0] = bus.o_valid;   ordy[0] = bus.o_ready;   oerr[0] = bus.o_error;
        ow[0] = bus.o_instruction;   oa[0] = 32'(bus.o_address);   modulo[0] = 256;
        ov[1] = bus_w.o_valid; ordy[1] = bus_w.o_ready; oerr[1] = bus_w.o_error;
        ow[1] = bus_w.o_instruction; oa[1] = 32'(bus_w.o_address); modulo[1] = 4;
        ev = (exp_q.size() != 0);
        er = (exp_q.size() < 2);
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (ov[d] !== ev) begin
                miscompares++;
                $display("FAIL step dut%0d o_valid: got %b expected %b at %0t", d, ov[d], ev, $time);
            end
            vectors++;
            if (ordy[d] !== er) begin
                miscompares++;
                $display("FAIL step dut%0d o_ready: got %b expected %b at %0t", d, ordy[d], er, $time);
            end
            vectors++;
            if (oerr[d] !== model_error) begin
                miscompares++;
                $display("FAIL step dut%0d o_error: got %b expected %b at %0t", d, oerr[d], model_error, $time);
            end
            if (ev) begin
                vectors++;
                if (ow[d] !== exp_q[0].word || oa[d] !== exp_q[0].addr % modulo[d]) begin
                    miscompares++;
                    $display("FAIL step dut%0d head: got %h@%0d expected %h@%0d at %0t", d, ow[d],
                             oa[d], exp_q[0].word, exp_q[0].addr % modulo[d], $time);
                end
            end
        end
        pop_m = ev && (bus.i_ready === 1'b1);
        acc   = (bus.i_valid === 1'b1) && er && !i_flush && !i_reset;
        if (i_reset || i_flush) begin
            exp_q.delete();
            model_count = 0;
            model_error = 1'b0;
        end else begin
            if (pop_m) void'(exp_q.pop_front());
            if (acc) begin
                if (model_legal(3'(bus.i_format), bus.i_funct3, bus.i_immediate)) begin
                    word = model_encode(3'(bus.i_format), bus.i_funct3, bus.i_arith,
                                        bus.i_destination_register, bus.i_source_register1,
                                        bus.i_source_register2, bus.i_immediate);
                    exp_q.push_back('{addr: model_count, word: word});
                    model_count++;
                end else begin
                    model_error = 1'b1;
                end
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic flush_pulse();
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        i_reset = 1'b1;
        i_flush = 1'b0;
        bus.i_ready = 1'b1;
        set_req(3'd0, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        repeat (2) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        idle();
        exp_q.delete();
        model_count = 0;
        model_error = 1'b0;
        vectors++;
        if ({bus.o_valid, bus.o_ready, bus.o_instruction, bus.o_address, bus.o_error} !==
            {1'b0, 1'b1, 32'h0, 8'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state: got valid=%b ready=%b word=%h addr=%0d err=%b, expected 0 1 00000000 0 0",
                     bus.o_valid, bus.o_ready, bus.o_instruction, bus.o_address, bus.o_error);
        end
        step();
    endtask

    task automatic test_fixed_words();
        logic [31:0] exp_word [6];
        int unsigned exp_addr [6];
        exp_word = '{32'h00500093, 32'h4030D113, 32'h0020A223, 32'hFE209CE3, 32'h010000EF, 32'h0};
        exp_addr = '{0, 0, 1, 0, 1, 0};
        bus.i_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 0 || i == 1 || i == 3) flush_pulse();
            case (i)
                0: set_req(FORMAT_OP_IMM, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
                1: set_req(FORMAT_OP_IMM, 3'd5, 1'b1, 5'd2, 5'd1, 5'd0, 32'd3);
                2: set_req(FORMAT_STORE,  3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd4);
                3: set_req(FORMAT_BRANCH, 3'd1, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8);
                default: set_req(FORMAT_JAL, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd16);
            endcase
            step();
            vectors++;
            if (bus.o_valid !== 1'b1 || bus.o_instruction !== exp_word[i] ||
                32'(bus.o_address) !== exp_addr[i]) begin
                miscompares++;
                $display("FAIL fixed_word_%0d: got valid=%b %h@%0d expected %h@%0d", i,
                         bus.o_valid, bus.o_instruction, bus.o_address, exp_word[i], exp_addr[i]);
            end
        end
        idle();
        step();
    endtask

    task automatic test_backpressure();
        int unsigned want [3];
        want = '{0, 1, 2};
        flush_pulse();
        bus.i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req(FORMAT_OP, 3'(i), i[0], 5'(i + 3), 5'(i + 4), 5'(i + 5), 32'd0);
            step();
        end
        step();
        vectors++;
        if (bus.o_ready !== 1'b0 || bus.o_address !== 8'd0) begin
            miscompares++;
            $display("FAIL backpressure_full: got ready=%b addr=%0d expected ready=0 addr=0",
                     bus.o_ready, bus.o_address);
        end
        bus.i_ready = 1'b1;
        for (int i = 1; i < 3; i++) begin
            step();
            if (i == 2) idle();
            vectors++;
            if (bus.o_valid !== 1'b1 || 32'(bus.o_address) !== want[i]) begin
                miscompares++;
                $display("FAIL backpressure_order_%0d: got valid=%b addr=%0d expected valid=1 addr=%0d",
                         i, bus.o_valid, bus.o_address, want[i]);
            end
        end
        idle();
        step();
        step();
    endtask

    task automatic test_drop_and_flush();
        flush_pulse();
        bus.i_ready = 1'b1;
        set_req(FORMAT_OP, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0);
        step();
        set_req(3'd6, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0);
        step();
        idle();
        vectors++;
        if (bus.o_error !== 1'b1 || bus.o_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL invalid_format: got err=%b valid=%b expected err=1 valid=0", bus.o_error, bus.o_valid);
        end
        set_req(FORMAT_OP_IMM, 3'd0, 1'b0, 5'd3, 5'd2, 5'd0, 32'd4096);
        step();
        idle();
`ifdef IMM_RANGE_CHECK_EN
        vectors++;
        if (bus.o_valid !== 1'b0 || bus.o_error !== 1'b1) begin
            miscompares++;
            $display("FAIL range_drop: got valid=%b err=%b expected valid=0 err=1", bus.o_valid, bus.o_error);
        end
        set_req(FORMAT_JAL, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8);
        step();
        idle();
`endif
        vectors++;
        if (bus.o_valid !== 1'b1 || bus.o_address !== 8'd1) begin
            miscompares++;
            $display("FAIL address_after_drop: got valid=%b addr=%0d expected valid=1 addr=1",
                     bus.o_valid, bus.o_address);
        end
`ifndef IMM_RANGE_CHECK_EN
        vectors++;
        if (bus.o_instruction !== 32'h00010193) begin
            miscompares++;
            $display("FAIL truncated_imm: got %h expected 00010193", bus.o_instruction);
        end
`endif
        set_req(FORMAT_STORE, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd4);
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        idle();
        vectors++;
        if (bus.o_error !== 1'b0 || bus.o_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_clear: got err=%b valid=%b expected err=0 valid=0", bus.o_error, bus.o_valid);
        end
        set_req(FORMAT_STORE, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd4);
        step();
        idle();
        vectors++;
        if (bus.o_address !== 8'd0 || bus.o_instruction !== 32'h0020A223) begin
            miscompares++;
            $display("FAIL after_flush: got %h@%0d expected 0020a223@0", bus.o_instruction, bus.o_address);
        end
        step();
    endtask

    task automatic test_address_wrap();
        flush_pulse();
        bus.i_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_req(FORMAT_OP_IMM, 3'd0, 1'b0, 5'(i), 5'd0, 5'd0, 32'(i));
            step();
            vectors++;
            if (bus_w.o_valid !== 1'b1 || bus_w.o_address !== 2'(i)) begin
                miscompares++;
                $display("FAIL wrap_%0d: got valid=%b addr=%0d expected valid=1 addr=%0d",
                         i, bus_w.o_valid, bus_w.o_address, i % 4);
            end
        end
        idle();
        step();
    endtask

    task automatic test_random();
        int bounds [18];
        logic [31:0] imm;
        logic [2:0]  fmt;
        bounds = '{-2048, 2047, 2048, -2049, 31, 32, -4096, 4094, 4095, 4096,
                   -4098, -1048576, 1048574, 1048575, 1048576, -1048578, 0, -1};
        flush_pulse();
        for (int n = 0; n < 600; n++) begin
            bus.i_ready = ($urandom_range(0, 3) != 0);
            i_flush     = ($urandom_range(0, 49) == 0);
            case ($urandom_range(0, 3))
                0:       imm = 32'(bounds[$urandom_range(0, 17)]);
                1:       imm = $urandom;
                default: imm = 32'(int'($urandom_range(0, 80)) - 40);
            endcase
            fmt = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            if ($urandom_range(0, 9) < 7)
                set_req(fmt, 3'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), imm);
            else
                idle();
            step();
        end
        i_flush = 1'b0;
        idle();
        bus.i_ready = 1'b1;
        repeat (3) step();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        i_flush     = 1'b0;
        test_reset();
        test_fixed_words();
        test_backpressure();
        test_drop_and_flush();
        test_address_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
